// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: latches EX results, runs the data SRAM load/store
// transaction, aligns/extends load data and hands results to the MEM_WB register.
module mem_stage_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_to_mem_valid,
   output logic                  mem_allowin,
   input  logic [31:0]           in_alu_result,
   input  logic [31:0]           in_store_data,
   input  logic [3:0]            in_mem_op,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_rd_en,
   input  logic [31:0]           in_directives,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_W-1:0]     data_addr,
   output logic [3:0]            data_wstrb,
   output logic [31:0]           data_wdata,
   input  logic                  data_addr_ok,
   input  logic                  data_data_ok,
   input  logic [31:0]           data_rdata,
   output logic                  mem_to_wb_valid,
   input  logic                  wb_allowin,
   output logic [31:0]           out_rd_data,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_rd_en,
   output logic [31:0]           out_directives
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   state_t                  r_state;
   state_t                  w_stateNext;
   logic                    r_valid;
   logic [31:0]             r_alu;
   logic [31:0]             r_storeData;
   logic [3:0]              r_memOp;
   logic [REG_ADDR_W-1:0]   r_rdAddr;
   logic                    r_rdEn;
   logic [31:0]             r_directives;
   logic [31:0]             r_result;

   logic                    w_isMem;
   logic                    w_isLoad;
   logic                    w_isStore;
   logic                    w_inIsMem;
   logic                    w_readyGo;
   logic                    w_accept;
   logic                    w_inReq;
   logic [1:0]              w_lane;

   // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] alignLoad(input logic [3:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] rdata);
      logic [31:0] byteSh;
      logic [31:0] halfSh;
      logic [31:0] res;
      byteSh = rdata >> {lane, 3'b000};
      halfSh = rdata >> {lane[1], 4'b0000};
      case (op)
         OP_LB:   res = {{24{byteSh[7]}}, byteSh[7:0]};
         OP_LBU:  res = {24'd0, byteSh[7:0]};
         OP_LH:   res = {{16{halfSh[15]}}, halfSh[15:0]};
         OP_LHU:  res = {16'd0, halfSh[15:0]};
         default: res = rdata;
      endcase
      return res;
   endfunction

   assign w_isLoad  = (r_memOp >= OP_LB) && (r_memOp <= OP_LW);
   assign w_isStore = (r_memOp >= OP_SB) && (r_memOp <= OP_SW);
   assign w_isMem   = w_isLoad || w_isStore;
   assign w_inIsMem = (in_mem_op >= OP_LB) && (in_mem_op <= OP_SW);
   assign w_lane    = r_alu[1:0];
   assign w_inReq   = (r_state == S_REQ);

   assign w_readyGo       = !w_isMem || (r_state == S_DONE);
   assign mem_allowin     = !r_valid || (w_readyGo && wb_allowin);
   assign mem_to_wb_valid = r_valid && w_readyGo;
   assign w_accept        = ex_to_mem_valid && mem_allowin;

   // Any cycle the stage opens up, the incoming op alone decides whether a new
   // transaction starts; REQ and WAIT advance on the SRAM regardless of wb_allowin.
   always_comb begin
      w_stateNext = r_state;
      if (mem_allowin) begin
         w_stateNext = (ex_to_mem_valid && w_inIsMem) ? S_REQ : S_IDLE;
      end else begin
         case (r_state)
            S_REQ:   if (data_addr_ok) w_stateNext = S_WAIT;
            S_WAIT:  if (data_data_ok) w_stateNext = S_DONE;
            default: w_stateNext = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_alu        <= '0;
         r_storeData  <= '0;
         r_memOp      <= '0;
         r_rdAddr     <= '0;
         r_rdEn       <= 1'b0;
         r_directives <= '0;
         r_result     <= '0;
      end else begin
         if (mem_allowin) begin
            r_valid <= ex_to_mem_valid;
         end
         if (w_accept) begin
            r_alu        <= in_alu_result;
            r_storeData  <= in_store_data;
            r_memOp      <= in_mem_op;
            r_rdAddr     <= in_rd_addr;
            r_rdEn       <= in_rd_en;
            r_directives <= in_directives;
         end
         if ((r_state == S_WAIT) && data_data_ok && w_isLoad) begin
            r_result <= alignLoad(r_memOp, w_lane, data_rdata);
         end
      end
   end

   // Request fields come straight from the held payload, so they stay stable
   // for as long as REQ waits on addr_ok.
   always_comb begin
      data_req   = w_inReq;
      data_wr    = w_inReq && w_isStore;
      data_size  = 2'd0;
      data_addr  = '0;
      data_wstrb = 4'b0000;
      data_wdata = 32'd0;
      if (w_inReq) begin
         data_addr = r_alu[ADDR_W-1:0];
         case (r_memOp)
            OP_LH, OP_LHU: data_size = 2'd1;
            OP_LW:         data_size = 2'd2;
            OP_SB: begin
               data_size  = 2'd0;
               data_wstrb = 4'b0001 << w_lane;
               data_wdata = {4{r_storeData[7:0]}};
            end
            OP_SH: begin
               data_size  = 2'd1;
               data_wstrb = w_lane[1] ? 4'b1100 : 4'b0011;
               data_wdata = {2{r_storeData[15:0]}};
            end
            OP_SW: begin
               data_size  = 2'd2;
               data_wstrb = 4'b1111;
               data_wdata = r_storeData;
            end
            default: data_size = 2'd0;
         endcase
      end
   end

   assign out_rd_data    = w_isLoad ? r_result : r_alu;
   assign out_rd_addr    = r_rdAddr;
   assign out_rd_en      = r_rdEn;
   assign out_directives = r_directives;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus queues expected MEM->WB results,
// a negedge monitor pops and compares them on every handoff.
module tb_mem_stage_ctrl;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_SH   = 4'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_to_mem_valid;
   logic        mem_allowin;
   logic [31:0] in_alu_result;
   logic [31:0] in_store_data;
   logic [3:0]  in_mem_op;
   logic [4:0]  in_rd_addr;
   logic        in_rd_en;
   logic [31:0] in_directives;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_to_wb_valid;
   logic        wb_allowin;
   logic [31:0] out_rd_data;
   logic [4:0]  out_rd_addr;
   logic        out_rd_en;
   logic [31:0] out_directives;

   typedef struct packed {
      logic [31:0] rdData;
      logic [4:0]  rdAddr;
      logic        rdEn;
      logic [31:0] dir;
   } expect_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic [31:0] result;
   } memVec_t;

   expect_t expQ[$];
   expect_t monGot;
   expect_t monWant;
   memVec_t vecs[$];
   int      nVectors     = 0;
   int      nMiscompares = 0;
   int      nOutputs     = 0;
   int      addrDelay    = 0;
   int      dataDelay    = 0;

   mem_stage_ctrl #(.ADDR_W(32), .REG_ADDR_W(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_to_mem_valid (ex_to_mem_valid),
      .mem_allowin     (mem_allowin),
      .in_alu_result   (in_alu_result),
      .in_store_data   (in_store_data),
      .in_mem_op       (in_mem_op),
      .in_rd_addr      (in_rd_addr),
      .in_rd_en        (in_rd_en),
      .in_directives   (in_directives),
      .data_req        (data_req),
      .data_wr         (data_wr),
      .data_size       (data_size),
      .data_addr       (data_addr),
      .data_wstrb      (data_wstrb),
      .data_wdata      (data_wdata),
      .data_addr_ok    (data_addr_ok),
      .data_data_ok    (data_data_ok),
      .data_rdata      (data_rdata),
      .mem_to_wb_valid (mem_to_wb_valid),
      .wb_allowin      (wb_allowin),
      .out_rd_data     (out_rd_data),
      .out_rd_addr     (out_rd_addr),
      .out_rd_en       (out_rd_en),
      .out_directives  (out_directives)
   );

   always #5 clk = ~clk;

   // Tiny data memory holding the hand-chosen words the load vectors expect.
   function automatic logic [31:0] sramWord(input logic [31:0] addr);
      logic [31:0] wordAddr;
      wordAddr = {addr[31:2], 2'b00};
      case (wordAddr)
         32'h0000_1000: return 32'h80AA_BBCC;
         32'h0000_3000: return 32'h1234_5678;
         32'h0000_4000: return 32'hCAFE_F00D;
         32'h0000_4004: return 32'h0BAD_BEEF;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   // SRAM responder: addr_ok after addrDelay extra cycles, data_ok after dataDelay more.
   initial begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'd0;
      forever begin
         logic [31:0] reqAddr;
         @(posedge clk); #1;
         if (data_req) begin
            reqAddr = data_addr;
            repeat (addrDelay) begin @(posedge clk); #1; end
            data_addr_ok = 1'b1;
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            repeat (dataDelay) begin @(posedge clk); #1; end
            data_rdata   = sramWord(reqAddr);
            data_data_ok = 1'b1;
            @(posedge clk); #1;
            data_data_ok = 1'b0;
         end
      end
   end

   // Each handoff consumes the oldest expected result.
   always @(negedge clk) begin
      if (mem_to_wb_valid && wb_allowin) begin
         monGot = '{out_rd_data, out_rd_addr, out_rd_en, out_directives};
         nOutputs++;
         nVectors++;
         if (expQ.size() == 0) begin
            nMiscompares++;
            $display("[TB] FAIL unexpected_output: got data=0x%08h rd=%0d, expected no output",
                     out_rd_data, out_rd_addr);
         end else begin
            monWant = expQ.pop_front();
            if (monGot !== monWant) begin
               nMiscompares++;
               $display("[TB] FAIL wb_result: got data=0x%08h rd=%0d en=%0d dir=0x%08h, expected data=0x%08h rd=%0d en=%0d dir=0x%08h",
                        monGot.rdData, monGot.rdAddr, monGot.rdEn, monGot.dir,
                        monWant.rdData, monWant.rdAddr, monWant.rdEn, monWant.dir);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present one instruction until the stage takes it; the expected result is queued at acceptance.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [4:0] rd, input logic en, input logic [31:0] dir,
                                input logic [31:0] expData);
      int budget;
      budget          = 0;
      ex_to_mem_valid = 1'b1;
      in_mem_op       = op;
      in_alu_result   = alu;
      in_store_data   = sdata;
      in_rd_addr      = rd;
      in_rd_en        = en;
      in_directives   = dir;
      while (!mem_allowin && budget < 100) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!mem_allowin) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL accept_timeout: mem_allowin=0 after %0d cycles, expected 1", budget);
      end else begin
         expQ.push_back('{expData, rd, en, dir});
         @(posedge clk); #1;
      end
      ex_to_mem_valid = 1'b0;
   endtask

   task automatic waitValid(input string name);
      int n;
      n = 0;
      while (!mem_to_wb_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!mem_to_wb_valid) begin
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL %s_timeout: mem_to_wb_valid=0 after %0d cycles, expected 1", name, n);
      end
   endtask

   initial begin
      int allowBad;
      int stableBad;
      int outsBefore;

      rst             = 1'b1;
      ex_to_mem_valid = 1'b0;
      in_alu_result   = 32'd0;
      in_store_data   = 32'd0;
      in_mem_op       = OP_NONE;
      in_rd_addr      = 5'd0;
      in_rd_en        = 1'b0;
      in_directives   = 32'd0;
      wb_allowin      = 1'b1;

      vecs.push_back('{OP_LBU, 32'h0000_1001, 32'h0,         4'b0000, 32'h0,         2'd0, 32'h0000_00BB});
      vecs.push_back('{OP_LH,  32'h0000_1000, 32'h0,         4'b0000, 32'h0,         2'd1, 32'hFFFF_BBCC});
      vecs.push_back('{OP_LHU, 32'h0000_1003, 32'h0,         4'b0000, 32'h0,         2'd1, 32'h0000_80AA});
      vecs.push_back('{OP_LW,  32'h0000_4006, 32'h0,         4'b0000, 32'h0,         2'd2, 32'h0BAD_BEEF});
      vecs.push_back('{OP_SB,  32'h0000_2001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5, 2'd0, 32'h0000_2001});
      vecs.push_back('{OP_SW,  32'h0000_2004, 32'hDEAD_C0DE, 4'b1111, 32'hDEAD_C0DE, 2'd2, 32'h0000_2004});

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_wb_valid", 32'(mem_to_wb_valid), 32'd0);
      checkOutput("reset_allowin",  32'(mem_allowin),     32'd1);
      checkOutput("reset_data_req", 32'(data_req),        32'd0);
      checkOutput("reset_wstrb",    32'(data_wstrb),      32'd0);
      checkOutput("reset_rd_data",  out_rd_data,          32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Non-memory ops, including an undefined op code, pass in one cycle without touching the SRAM.
      applyStimulus(OP_NONE, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 32'hAAAA_0001, 32'h0000_1234);
      @(negedge clk);
      checkOutput("alu_valid_next_cycle", 32'(mem_to_wb_valid), 32'd1);
      checkOutput("alu_no_req",           32'(data_req),        32'd0);
      @(posedge clk); #1;
      applyStimulus(4'hF, 32'h0000_0777, 32'h0, 5'd4, 1'b0, 32'hAAAA_0002, 32'h0000_0777);
      @(negedge clk);
      checkOutput("undef_op_valid", 32'(mem_to_wb_valid), 32'd1);
      checkOutput("undef_op_no_req", 32'(data_req),       32'd0);
      @(posedge clk); #1;

      // LB with slow SRAM: the stage must refuse new work for the whole transaction.
      addrDelay = 2;
      dataDelay = 2;
      applyStimulus(OP_LB, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 32'hAAAA_0003, 32'hFFFF_FF80);
      @(negedge clk);
      checkOutput("lb_req",   32'(data_req),   32'd1);
      checkOutput("lb_wr",    32'(data_wr),    32'd0);
      checkOutput("lb_size",  32'(data_size),  32'd0);
      checkOutput("lb_wstrb", 32'(data_wstrb), 32'd0);
      checkOutput("lb_addr",  data_addr,       32'h0000_1003);
      allowBad = 0;
      for (int n = 0; n < 50 && !mem_to_wb_valid; n++) begin
         if (mem_allowin) allowBad++;
         @(negedge clk);
      end
      checkOutput("lb_allowin_held", 32'(allowBad), 32'd0);
      waitValid("lb");
      @(posedge clk); #1;

      // SH: upper half-lane, data replicated, valid only after data_ok.
      addrDelay = 0;
      dataDelay = 1;
      applyStimulus(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 5'd7, 1'b1, 32'hAAAA_0004, 32'h0000_2002);
      @(negedge clk);
      checkOutput("sh_wr",       32'(data_wr),        32'd1);
      checkOutput("sh_wstrb",    32'(data_wstrb),     32'b1100);
      checkOutput("sh_wdata",    data_wdata,          32'hBEEF_BEEF);
      checkOutput("sh_size",     32'(data_size),      32'd1);
      checkOutput("sh_not_valid", 32'(mem_to_wb_valid), 32'd0);
      waitValid("sh");
      @(posedge clk); #1;

      // Remaining load/store lane and extension cases.
      addrDelay = 1;
      dataDelay = 0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].sdata, 5'(10 + i), 1'b1,
                       32'hD000_0000 | 32'(i), vecs[i].result);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_req", i),   32'(data_req),   32'd1);
         checkOutput($sformatf("vec%0d_wr", i),    32'(data_wr),    32'(vecs[i].op >= OP_SB));
         checkOutput($sformatf("vec%0d_size", i),  32'(data_size),  32'(vecs[i].size));
         checkOutput($sformatf("vec%0d_wstrb", i), 32'(data_wstrb), 32'(vecs[i].wstrb));
         if (vecs[i].op >= OP_SB) begin
            checkOutput($sformatf("vec%0d_wdata", i), data_wdata, vecs[i].wdata);
         end
         waitValid($sformatf("vec%0d", i));
         @(posedge clk); #1;
      end

      // Back-pressure: result held in DONE while wb_allowin=0; EX accepted only once it rises.
      addrDelay  = 0;
      dataDelay  = 0;
      wb_allowin = 1'b0;
      applyStimulus(OP_LW, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 32'hB000_0001, 32'h1234_5678);
      waitValid("bp_lw");
      @(posedge clk); #1;
      ex_to_mem_valid = 1'b1;
      in_mem_op       = OP_NONE;
      in_alu_result   = 32'h0000_0055;
      in_rd_addr      = 5'd4;
      in_rd_en        = 1'b1;
      in_directives   = 32'hB000_0002;
      allowBad  = 0;
      stableBad = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_allowin) allowBad++;
         if (!mem_to_wb_valid || out_rd_data !== 32'h1234_5678 || out_rd_addr !== 5'd9 ||
             out_directives !== 32'hB000_0001) stableBad++;
      end
      checkOutput("bp_allowin_low", 32'(allowBad),  32'd0);
      checkOutput("bp_out_stable",  32'(stableBad), 32'd0);
      @(posedge clk); #1;
      wb_allowin = 1'b1;
      @(negedge clk);
      checkOutput("bp_allowin_on_release", 32'(mem_allowin), 32'd1);
      expQ.push_back('{32'h0000_0055, 5'd4, 1'b1, 32'hB000_0002});
      @(posedge clk); #1;
      ex_to_mem_valid = 1'b0;
      @(posedge clk); #1;

      // Back-to-back LW with 1-cycle SRAM: second request starts right after the first handoff.
      applyStimulus(OP_LW, 32'h0000_4000, 32'h0, 5'd12, 1'b1, 32'hC000_0001, 32'hCAFE_F00D);
      applyStimulus(OP_LW, 32'h0000_4004, 32'h0, 5'd13, 1'b1, 32'hC000_0002, 32'h0BAD_BEEF);
      @(negedge clk);
      checkOutput("b2b_second_req", 32'(data_req), 32'd1);
      checkOutput("b2b_second_addr", data_addr,    32'h0000_4004);
      waitValid("b2b");
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset while in WAIT; the late data_ok must not produce a result.
      addrDelay = 0;
      dataDelay = 3;
      applyStimulus(OP_LW, 32'h0000_4000, 32'h0, 5'd14, 1'b1, 32'hE000_0001, 32'hCAFE_F00D);
      for (int n = 0; n < 20 && data_req; n++) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(expQ.pop_back());
      outsBefore = nOutputs;
      @(negedge clk);
      checkOutput("rst_wait_valid",   32'(mem_to_wb_valid), 32'd0);
      checkOutput("rst_wait_req",     32'(data_req),        32'd0);
      checkOutput("rst_wait_allowin", 32'(mem_allowin),     32'd1);
      repeat (8) @(negedge clk);
      checkOutput("rst_late_data_ok_ignored", 32'(nOutputs - outsBefore), 32'd0);
      checkOutput("rst_req_stays_low",        32'(data_req),              32'd0);

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
